// File: rtl/pic_ctrl_sync_pkg.sv
// Shared constants and types for the pic_ctrl_sync interrupt controller.
// Register addresses, EOI/mode bit positions and the INTA sequencer states.
package pic_pkg;

   localparam logic [1:0] ADDR_IMR  = 2'd0;
   localparam logic [1:0] ADDR_BASE = 2'd1;
   localparam logic [1:0] ADDR_MODE = 2'd2;
   localparam logic [1:0] ADDR_EOI  = 2'd3;

   localparam int MODE_LTIM_BIT = 0;
   localparam int MODE_AEOI_BIT = 1;
   localparam int MODE_ROT_BIT  = 2;

   localparam int EOI_NS_BIT = 5;
   localparam int EOI_SP_BIT = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK1 = 2'd1,
      ACK2 = 2'd2
   } ack_state_t;

endpackage

// File: rtl/pic_ctrl_sync_prio_resolver.sv
// Combinational find-highest: scans vec starting at index 'start' (highest priority)
// and wrapping modulo N; returns whether any bit is set and the winning index.
module pic_prio_resolver #(
   parameter int N = 8
) (
   input  logic [N-1:0]         vec,
   input  logic [$clog2(N)-1:0] start,
   output logic                 valid,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   // Scan from lowest to highest priority so the highest-priority hit is written last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[start + IW'(i)]) begin
            valid = 1'b1;
            idx   = start + IW'(i);
         end
      end
   end

endmodule

// File: rtl/pic_ctrl_sync.sv
// 8259A-style interrupt control logic: IRR/IMR/ISR, fully nested priority and INTA sequencer.
// Optional rotating priority is compiled in when PIC_ROTATE_EN is defined.
module pic_ctrl_sync
   import pic_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int VEC_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [1:0]         wr_addr,
   input  logic [15:0]        wr_data,
   input  logic [NUM_IRQ-1:0] ir,
   input  logic               inta_n,
   output logic               int_o,
   output logic [VEC_W-1:0]   vec_o,
   output logic               vec_valid,
   output logic [NUM_IRQ-1:0] irr_o,
   output logic [NUM_IRQ-1:0] isr_o,
   output logic [NUM_IRQ-1:0] imr_o
);

   localparam int IDX_W = $clog2(NUM_IRQ);

   logic [NUM_IRQ-1:0]     ir_q, irr, isr, imr, req;
   logic [VEC_W-1:IDX_W]   base_hi;
   logic                   ltim, aeoi, inta_n_q, spurious;
   logic [IDX_W-1:0]       w, start;
   ack_state_t             state, state_next;
   logic                   do_ack1, do_ack2, inta_fall, int_cond;
   logic                   req_valid, isr_valid;
   logic [IDX_W-1:0]       req_idx, isr_idx;
   logic [NUM_IRQ-1:0]     ack_clr, eoi_clr, aeoi_clr, irr_next, isr_next;
   logic                   wr_imr, wr_base, wr_mode, wr_eoi;
   logic                   unused_wr;

   assign unused_wr = ^wr_data;

   assign wr_imr  = wr_en && (wr_addr == ADDR_IMR);
   assign wr_base = wr_en && (wr_addr == ADDR_BASE);
   assign wr_mode = wr_en && (wr_addr == ADDR_MODE);
   assign wr_eoi  = wr_en && (wr_addr == ADDR_EOI);

   assign req       = irr & ~imr;
   assign inta_fall = inta_n_q & ~inta_n;

`ifdef PIC_ROTATE_EN
   logic             rot;
   logic [IDX_W-1:0] lowest_prio;
   logic             rot_upd;
   logic [IDX_W-1:0] rot_k;
   assign start = lowest_prio + 1'b1;
`else
   assign start = '0;
`endif

   pic_prio_resolver #(.N(NUM_IRQ)) u_req_res (
      .vec(req), .start(start), .valid(req_valid), .idx(req_idx)
   );
   pic_prio_resolver #(.N(NUM_IRQ)) u_isr_res (
      .vec(isr), .start(start), .valid(isr_valid), .idx(isr_idx)
   );

   // Ranks are distances from the highest-priority slot; wrap is free since NUM_IRQ is 2^n.
   assign int_cond = req_valid && (!isr_valid || ((req_idx - start) < (isr_idx - start)));

   // NOTE: every signal written in this block gets a default first, so no latch is inferred.
   always_comb begin
      state_next = state;
      do_ack1    = 1'b0;
      do_ack2    = 1'b0;
      case (state)
         IDLE: if (inta_fall) begin state_next = ACK1; do_ack1 = 1'b1; end
         ACK1: if (inta_fall) begin state_next = ACK2; do_ack2 = 1'b1; end
         ACK2: if (inta_n) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ack_clr  = (do_ack1 && int_cond) ? (NUM_IRQ'(1) << req_idx) : '0;
      aeoi_clr = (do_ack2 && aeoi && !spurious) ? (NUM_IRQ'(1) << w) : '0;
      eoi_clr  = '0;
      if (wr_eoi) begin
         if (wr_data[EOI_NS_BIT]) begin
            if (isr_valid) eoi_clr = NUM_IRQ'(1) << isr_idx;
         end else if (wr_data[EOI_SP_BIT]) begin
            eoi_clr = NUM_IRQ'(1) << wr_data[IDX_W-1:0];
         end
      end
      // A fresh rising edge always wins over the acknowledge clear.
      if (ltim) irr_next = (ir  & ~ack_clr) | (ir & ~ir_q);
      else      irr_next = (irr & ~ack_clr) | (ir & ~ir_q);
      isr_next = ((isr & ~eoi_clr) | ack_clr) & ~aeoi_clr;
`ifdef PIC_ROTATE_EN
      rot_upd = 1'b0;
      rot_k   = '0;
      if (|(aeoi_clr & isr)) begin
         rot_upd = rot;
         rot_k   = w;
      end
      if (|(eoi_clr & isr)) begin
         rot_upd = rot;
         rot_k   = wr_data[EOI_NS_BIT] ? isr_idx : wr_data[IDX_W-1:0];
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_q      <= '0;
         inta_n_q  <= 1'b1;
         irr       <= '0;
         isr       <= '0;
         imr       <= '0;
         base_hi   <= '0;
         ltim      <= 1'b0;
         aeoi      <= 1'b0;
         w         <= '0;
         spurious  <= 1'b0;
         int_o     <= 1'b0;
         vec_o     <= '0;
         vec_valid <= 1'b0;
      end else begin
         ir_q      <= ir;
         inta_n_q  <= inta_n;
         irr       <= irr_next;
         isr       <= isr_next;
         int_o     <= do_ack1 ? 1'b0 : int_cond;
         vec_valid <= do_ack2;
         if (wr_imr)  imr     <= wr_data[NUM_IRQ-1:0];
         if (wr_base) base_hi <= wr_data[VEC_W-1:IDX_W];
         if (wr_mode) begin
            ltim <= wr_data[MODE_LTIM_BIT];
            aeoi <= wr_data[MODE_AEOI_BIT];
         end
         if (do_ack1) begin
            w        <= int_cond ? req_idx : IDX_W'(NUM_IRQ - 1);
            spurious <= !int_cond;
         end
         if (do_ack2) vec_o <= {base_hi, w};
      end
   end

`ifdef PIC_ROTATE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rot         <= 1'b0;
         lowest_prio <= IDX_W'(NUM_IRQ - 1);
      end else begin
         if (wr_mode) rot <= wr_data[MODE_ROT_BIT];
         if (rot_upd) lowest_prio <= rot_k;
      end
   end
`endif

   assign irr_o = irr;
   assign isr_o = isr;
   assign imr_o = imr;

endmodule

// File: tb/tb_pic_ctrl_sync.sv
// Directed self-checking bench for pic_ctrl_sync (NUM_IRQ=8, VEC_W=8).
// The rotating-priority steps run only when PIC_ROTATE_EN is defined.
module tb_pic_ctrl_sync;

   localparam int N  = 8;
   localparam int VW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [1:0]    wr_addr;
   logic [15:0]   wr_data;
   logic [N-1:0]  ir;
   logic          inta_n;
   logic          int_o;
   logic [VW-1:0] vec_o;
   logic          vec_valid;
   logic [N-1:0]  irr_o, isr_o, imr_o;

   int n_cmp = 0;
   int n_err = 0;

   pic_ctrl_sync #(.NUM_IRQ(N), .VEC_W(VW)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .ir(ir), .inta_n(inta_n), .int_o(int_o), .vec_o(vec_o), .vec_valid(vec_valid),
      .irr_o(irr_o), .isr_o(isr_o), .imr_o(imr_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit after the last one.
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse(input logic [N-1:0] bits);
      ir = bits; tick();
      ir = '0;   tick();
   endtask

   task automatic fall();
      inta_n = 1'b0; tick();
   endtask

   task automatic rise();
      inta_n = 1'b1; tick();
   endtask

   task automatic ack();
      fall(); rise(); fall(); rise();
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; ir = '0; inta_n = 1'b1;
      tick(2);
      check("rst_int", int_o, 0);
      check("rst_vec", vec_o, 0);
      check("rst_valid", vec_valid, 0);
      check("rst_irr", irr_o, 0);
      check("rst_isr", isr_o, 0);
      check("rst_imr", imr_o, 0);
      reset = 1'b0;
      tick();

      // Edge mode, single request on IR3.
      wr(2'd1, 16'h0040);
      wr(2'd2, 16'h0000);
      ir = 8'h08; tick();
      check("t1_irr", irr_o, 8'h08);
      check("t1_int_lag", int_o, 0);
      ir = '0; tick();
      check("t1_int", int_o, 1);
      fall();
      check("t1_ack1_isr", isr_o, 8'h08);
      check("t1_ack1_irr", irr_o, 8'h00);
      check("t1_ack1_int", int_o, 0);
      rise();
      check("t1_between_valid", vec_valid, 0);
      fall();
      check("t1_vec", vec_o, 8'h43);
      check("t1_valid", vec_valid, 1);
      rise();
      check("t1_valid_drop", vec_valid, 0);
      check("t1_isr_hold", isr_o, 8'h08);
      wr(2'd3, 16'h0020);
      check("t1_ns_eoi", isr_o, 8'h00);

      // Nesting: IR5 in service, IR2 preempts.
      pulse(8'h20);
      check("t2_int5", int_o, 1);
      ack();
      check("t2_isr5", isr_o, 8'h20);
      check("t2_vec5", vec_o, 8'h45);
      pulse(8'h04);
      check("t2_int2", int_o, 1);
      ack();
      check("t2_isr24", isr_o, 8'h24);
      check("t2_vec2", vec_o, 8'h42);
      wr(2'd3, 16'h0020);
      check("t2_ns_eoi", isr_o, 8'h20);
      // EOI in the same cycle as ACK1 acts on the pre-set ISR.
      pulse(8'h04);
      check("t2_int2b", int_o, 1);
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'h0020; inta_n = 1'b0;
      tick();
      wr_en = 1'b0;
      check("t2_eoi_ack1", isr_o, 8'h04);
      rise(); fall(); rise();
      wr(2'd3, 16'h0020);
      check("t2_clear", isr_o, 8'h00);

      // Masking.
      wr(2'd0, 16'h0008);
      check("t3_imr", imr_o, 8'h08);
      pulse(8'h08);
      check("t3_irr", irr_o, 8'h08);
      check("t3_masked", int_o, 0);
      wr(2'd0, 16'h0000);
      check("t3_unmask_lag", int_o, 0);
      tick();
      check("t3_unmask", int_o, 1);
      ack();
      check("t3_vec", vec_o, 8'h43);
      wr(2'd3, 16'h0043);
      check("t3_sp_eoi", isr_o, 8'h00);

      // Spurious acknowledge.
      fall();
      check("t4_isr", isr_o, 8'h00);
      rise(); fall();
      check("t4_vec", vec_o, 8'h47);
      check("t4_valid", vec_valid, 1);
      rise();

      // Automatic EOI.
      wr(2'd2, 16'h0002);
      pulse(8'h02);
      fall();
      check("t5_isr_set", isr_o, 8'h02);
      rise(); fall();
      check("t5_vec", vec_o, 8'h41);
      check("t5_isr_aeoi", isr_o, 8'h00);
      rise();

      // Level mode with AEOI, IR1 held high.
      wr(2'd2, 16'h0003);
      ir = 8'h02; tick(2);
      check("t5l_int", int_o, 1);
      fall();
      check("t5l_irr_clr", irr_o, 8'h00);
      check("t5l_isr", isr_o, 8'h02);
      rise();
      check("t5l_irr_back", irr_o, 8'h02);
      check("t5l_int_nested", int_o, 0);
      fall();
      check("t5l_isr_aeoi", isr_o, 8'h00);
      rise();
      check("t5l_reassert", int_o, 1);
      ir = '0;
      wr(2'd2, 16'h0000);
      tick(2);
      check("t5l_idle", int_o, 0);

      // Reset during ACK1.
      pulse(8'h08);
      fall();
      reset = 1'b1; inta_n = 1'b1;
      tick();
      check("t6_int", int_o, 0);
      check("t6_vec", vec_o, 0);
      check("t6_valid", vec_valid, 0);
      check("t6_irr", irr_o, 0);
      check("t6_isr", isr_o, 0);
      check("t6_imr", imr_o, 0);
      reset = 1'b0;
      tick();
      fall();
      check("t6_fsm_idle", vec_valid, 0);
      rise(); fall();
      check("t6_vec_spur", vec_o, 8'h07);
      check("t6_valid_spur", vec_valid, 1);
      rise();

`ifdef PIC_ROTATE_EN
      // Rotating priority: after EOI of IR0, IR1 outranks IR0.
      wr(2'd1, 16'h0040);
      wr(2'd2, 16'h0004);
      pulse(8'h01);
      ack();
      check("t7_isr0", isr_o, 8'h01);
      wr(2'd3, 16'h0020);
      check("t7_eoi", isr_o, 8'h00);
      pulse(8'h03);
      ack();
      check("t7_vec", vec_o, 8'h41);
      check("t7_isr1", isr_o, 8'h02);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pic_ctrl_sync.md
Name: pic_ctrl_sync

Overview:
Synchronous, parametrised successor to the 8259A-style control logic. Holds the IRR, IMR and ISR for NUM_IRQ request lines and resolves priority in fully nested mode. Runs the two-pulse INTA sequence and produces the interrupt vector. It sits between the bus read/write decode and the CPU interrupt interface. All state is clocked; there are no combinational latches or event-driven state.

Parameters:
NUM_IRQ, 8, number of request lines; legal values 4, 8, 16 (power of two)
IDX_W, $clog2(NUM_IRQ), index width (derived, not overridden)
VEC_W, 8, vector width; must be >= IDX_W+1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  register write strobe, one cycle per write
wr_addr  in  2  register select: 0=IMR, 1=vector base, 2=mode, 3=EOI command
wr_data  in  16  write data; low NUM_IRQ bits for IMR, low VEC_W bits for base
ir  in  NUM_IRQ  interrupt request lines, synchronous to clk
inta_n  in  1  interrupt acknowledge, active low, synchronous to clk
int_o  out  1  interrupt request to CPU
vec_o  out  VEC_W  interrupt vector
vec_valid  out  1  one-cycle strobe: vec_o is valid
irr_o  out  NUM_IRQ  IRR snapshot
isr_o  out  NUM_IRQ  ISR snapshot
imr_o  out  NUM_IRQ  IMR snapshot

Behaviour:
- Interface decision: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: irr, isr, imr and base all 0; mode = {aeoi=0, ltim=0}; int_o=0; vec_o=0; vec_valid=0; FSM=IDLE; ir_q=0.
- Mode register: wr_data[0]=ltim (1 = level-triggered), wr_data[1]=aeoi.
- Edge mode: IRR bit sets on a rising edge of ir, detected against the one-cycle-delayed ir_q. The bit clears only when that level is acknowledged.
- Level mode: IRR follows ir each cycle, except that the bit being acknowledged is cleared in the ACK1 cycle.
- Masked requests: req = irr & ~imr.
- Priority: fixed; index 0 is highest.
- Fully nested rule: int_o=1 when the highest-priority req bit is strictly higher than the highest set ISR bit (any bit if isr=0). int_o is registered, so it lags the IRR update by 1 cycle.
- INTA falling edge: detected as inta_n_q=1 and inta_n=0.
- FSM states: IDLE, ACK1, ACK2.
- IDLE -> ACK1 on the first falling edge:
  - latch winner index w;
  - if a qualifying req exists: set isr[w], clear irr[w], and clear int_o;
  - otherwise flag spurious: w=NUM_IRQ-1, no ISR change.
- ACK1 -> ACK2 on the second falling edge:
  - vec_o = {base[VEC_W-1:IDX_W], w}, and vec_valid=1 for exactly that cycle;
  - if aeoi=1 and not spurious, clear isr[w] in the same cycle.
- ACK2 -> IDLE when inta_n returns high.
- Extra INTA falling edges while in ACK2 are ignored.
- EOI command (wr_addr=3):
  - wr_data[5]=1: non-specific EOI, clears the highest-priority set ISR bit (no-op if isr=0);
  - wr_data[6]=1 with wr_data[5]=0: specific EOI, clears isr[wr_data[IDX_W-1:0]];
  - both 0: no-op.
- Simultaneous events:
  - an EOI write in the same cycle as an ACK1 ISR set takes effect on the pre-set ISR, and the new bit survives;
  - an IMR write in the same cycle as ACK1 does not alter the already-latched winner;
  - a rising ir edge on the bit being cleared in the same cycle leaves the IRR bit set.
- IMR write: takes effect on req in the next cycle.
- Reset mid-sequence: FSM returns to IDLE, vec_valid drops immediately, and any pending INTA pulse is dropped.

Optional Feature:
PIC_ROTATE_EN.
- Defined:
  - adds a rotating-priority mode, mode bit wr_data[2]=rot;
  - with rot=1, every EOI that clears ISR bit k sets lowest_prio=k, so priority order becomes k+1, k+2, ... wrapping modulo NUM_IRQ;
  - the resolver and the non-specific EOI both use the rotated order;
  - lowest_prio resets to NUM_IRQ-1.
- Undefined: wr_data[2] is ignored, there is no lowest_prio register, and priority is fixed.

Decomposition:
- Package pic_pkg:
  - register address constants (ADDR_IMR, ADDR_BASE, ADDR_MODE, ADDR_EOI);
  - FSM state typedef ack_state_t {IDLE, ACK1, ACK2};
  - EOI bit positions.
- One natural sub-module: pic_prio_resolver, a combinational find-highest taking vector plus rotation offset and returning valid and index. Instantiate it twice: once for req, once for isr.

Test Plan:
- Edge mode, imr=0, base=0x40, pulse ir[3] -> int_o=1 after 2 cycles; on two INTA pulses, vec_o=0x43 with vec_valid for 1 cycle, isr=0x08, irr=0x00.
- ir[5] active, then ir[2] while isr[5] set -> int_o reasserts for IR2; after acknowledge, isr=0x24. Non-specific EOI -> isr=0x20.
- imr=0x08, pulse ir[3] -> irr=0x08 but int_o stays 0. Write imr=0 -> int_o=1 two cycles later.
- INTA sequence with no request -> vec_o=base|7 (NUM_IRQ=8), isr unchanged at 0.
- aeoi=1, ir[1] acknowledged -> isr[1] is set after ACK1 and cleared in the vec_valid cycle. Level mode with ir[1] held high -> int_o reasserts after ACK2.
- Assert reset during ACK1 -> next cycle all outputs are at reset values. With PIC_ROTATE_EN and rot=1, EOI of IR0 -> IR1 wins over IR0 when both are pending.
